program_counter_stack: RTL and testbench

PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_return_stack.sv | 77 +++++++
 rtl/program_counter_stack.sv | 100 ++++++++++
 tb/tb_program_counter_stack.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return stack block:
// operation encoding, default sizes and the control priority decode.
package pc_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int PC_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JUMP = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_REL  = 3'd5
    } pc_op_e;

    // Return beats call beats jump beats relative branch beats increment.
    function automatic pc_op_e pc_decode(input logic ret_n, input logic call_n,
                                         input logic jump_n, input logic rel_n,
                                         input logic inc);
        if (!ret_n)       return PC_RET;
        else if (!call_n) return PC_CALL;
        else if (!jump_n) return PC_JUMP;
        else if (!rel_n)  return PC_REL;
        else if (inc)     return PC_INC;
        else              return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses. Overflowing pushes and underflowing pops are
// dropped and raise a sticky error; occupancy flags are registered.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = PC_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_empty;
    logic             r_full;
    logic             r_err;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_do_push)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (w_do_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            if ((i_push & r_full) | (i_pop & r_empty))
                r_err <= 1'b1;
        end
    end

    // Entry storage needs no reset: the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (r_cnt == CW'(i)))
                r_mem[i] <= i_data;
        end
    end

    always_comb begin
        o_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i + 1))
                o_top = r_mem[i];
        end
    end

    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_err   = r_err;

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment/jump/call/return and a return-address stack.
// Define PC_REL_BRANCH_EN to add the relBar port and pc-relative branch adder.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = PC_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetBar,
    input  logic             incEn,
    input  logic             doJumpBar,
    input  logic             doCallBar,
    input  logic             doRetBar,
`ifdef PC_REL_BRANCH_EN
    input  logic             relBar,
`endif
    input  logic [WIDTH-1:0] dbus,
    output logic [WIDTH-1:0] pc,
    output logic             co,
    output logic             stackEmpty,
    output logic             stackFull,
    output logic             stackErr
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_top;
    logic             w_rel_n;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_err;
    pc_op_e           w_op;

`ifdef PC_REL_BRANCH_EN
    assign w_rel_n = relBar;
`else
    assign w_rel_n = 1'b1;
`endif

    assign w_op     = pc_decode(doRetBar, doCallBar, doJumpBar, w_rel_n, incEn);
    assign w_pc_inc = r_pc + WIDTH'(1);

    always_comb begin
        w_pc_nxt = r_pc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (w_op)
            PC_INC:  w_pc_nxt = w_pc_inc;
            PC_JUMP: w_pc_nxt = dbus;
            // A call on a full stack still branches; the stack drops the push.
            PC_CALL: begin
                w_push   = 1'b1;
                w_pc_nxt = dbus;
            end
            PC_RET: begin
                w_pop = 1'b1;
                if (!w_empty)
                    w_pc_nxt = w_top;
            end
`ifdef PC_REL_BRANCH_EN
            // Same-width add wraps, so the offset is effectively sign-extended.
            PC_REL:  w_pc_nxt = r_pc + dbus;
`endif
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar)
            r_pc <= '0;
        else
            r_pc <= w_pc_nxt;
    end

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (resetBar),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_err   (w_err)
    );

    assign pc         = r_pc;
    assign co         = incEn & (&r_pc);
    assign stackEmpty = w_empty;
    assign stackFull  = w_full;
    assign stackErr   = w_err;

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// pops and compares after each clock edge or asynchronous reset assertion.
module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       resetBar = 1'b1;
    logic       incEn = 1'b0;
    logic       doJumpBar = 1'b1;
    logic       doCallBar = 1'b1;
    logic       doRetBar = 1'b1;
`ifdef PC_REL_BRANCH_EN
    logic       relBar = 1'b1;
`endif
    logic [7:0] dbus = 8'h00;
    logic [7:0] pc;
    logic       co;
    logic       stackEmpty;
    logic       stackFull;
    logic       stackErr;

    typedef struct {
        logic [7:0] pc;
        logic       emp;
        logic       ful;
        logic       err;
        logic       co;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    program_counter_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .resetBar   (resetBar),
        .incEn      (incEn),
        .doJumpBar  (doJumpBar),
        .doCallBar  (doCallBar),
        .doRetBar   (doRetBar),
`ifdef PC_REL_BRANCH_EN
        .relBar     (relBar),
`endif
        .dbus       (dbus),
        .pc         (pc),
        .co         (co),
        .stackEmpty (stackEmpty),
        .stackFull  (stackFull),
        .stackErr   (stackErr)
    );

    task automatic expect_push(input logic [7:0] epc, input logic ee, input logic ef,
                               input logic er, input logic eco, input string nm);
        exp_t e;
        e.pc = epc; e.emp = ee; e.ful = ef; e.err = er; e.co = eco; e.nm = nm;
        q.push_back(e);
    endtask

    // One operation for the coming edge; co expectation follows incEn and new pc.
    task automatic op(input logic rn, input logic cn, input logic jn, input logic inc,
                      input logic [7:0] d, input logic [7:0] epc, input logic ee,
                      input logic ef, input logic er, input string nm);
        @(negedge clk);
        doRetBar = rn; doCallBar = cn; doJumpBar = jn; incEn = inc; dbus = d;
`ifdef PC_REL_BRANCH_EN
        relBar = 1'b1;
`endif
        expect_push(epc, ee, ef, er, inc && (epc == 8'hFF), nm);
    endtask

    // Asynchronous reset pulse away from the clock edge; optional increment on
    // the first edge after release.
    task automatic rst_pulse(input logic inc, input string nm);
        @(negedge clk);
        doRetBar = 1'b1; doCallBar = 1'b1; doJumpBar = 1'b1; incEn = inc;
`ifdef PC_REL_BRANCH_EN
        relBar = 1'b1;
`endif
        expect_push(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, nm);
        #2 resetBar = 1'b0;
        #2 resetBar = 1'b1;
        if (inc)
            expect_push(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, "first_edge_after_reset");
    endtask

`ifdef PC_REL_BRANCH_EN
    task automatic rel(input logic [7:0] d, input logic [7:0] epc, input logic ee,
                       input string nm);
        @(negedge clk);
        doRetBar = 1'b1; doCallBar = 1'b1; doJumpBar = 1'b1; incEn = 1'b1; dbus = d;
        relBar = 1'b0;
        expect_push(epc, ee, 1'b0, 1'b0, epc == 8'hFF, nm);
    endtask
`endif

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge resetBar);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (pc === e.pc && stackEmpty === e.emp && stackFull === e.ful &&
                    stackErr === e.err && co === e.co)
                    passed++;
                else
                    $display("FAIL %s: got pc=%h emp=%b full=%b err=%b co=%b, want pc=%h emp=%b full=%b err=%b co=%b",
                             e.nm, pc, stackEmpty, stackFull, stackErr, co,
                             e.pc, e.emp, e.ful, e.err, e.co);
            end
        end
    end

    initial begin : stim
        #2;
        expect_push(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "reset_state");
        resetBar = 1'b0;
        #20 resetBar = 1'b1;

        // Count through the full range and wrap.
        for (int k = 1; k <= 259; k++)
            op(1, 1, 1, 1, 8'h00, 8'(k), 1, 0, 0, "inc_count");
        op(1, 1, 1, 0, 8'h00, 8'h03, 1, 0, 0, "hold");

        // Jump overrides increment.
        op(1, 1, 0, 0, 8'h10, 8'h10, 1, 0, 0, "jump_10");
        op(1, 1, 0, 1, 8'h80, 8'h80, 1, 0, 0, "jump_over_inc");

        // Nested call/return.
        op(1, 1, 0, 0, 8'h20, 8'h20, 1, 0, 0, "jump_20");
        op(1, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0, "call_40");
        op(1, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0, "call_60");
        op(0, 1, 1, 0, 8'h00, 8'h41, 0, 0, 0, "ret_41");
        op(0, 1, 1, 0, 8'h00, 8'h21, 1, 0, 0, "ret_21");

        // Overflow and underflow.
        op(1, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0, "call1");
        op(1, 0, 1, 0, 8'h50, 8'h50, 0, 0, 0, "call2");
        op(1, 0, 1, 0, 8'h70, 8'h70, 0, 0, 0, "call3");
        op(1, 0, 1, 0, 8'h90, 8'h90, 0, 1, 0, "call4_full");
        op(1, 0, 1, 0, 8'hB0, 8'hB0, 0, 1, 1, "call5_overflow");
        op(0, 1, 1, 0, 8'h00, 8'h71, 0, 0, 1, "ret1");
        op(0, 1, 1, 0, 8'h00, 8'h51, 0, 0, 1, "ret2");
        op(0, 1, 1, 0, 8'h00, 8'h31, 0, 0, 1, "ret3");
        op(0, 1, 1, 0, 8'h00, 8'h22, 1, 0, 1, "ret4_empty");
        op(0, 1, 1, 0, 8'h00, 8'h22, 1, 0, 1, "ret_underflow");
        op(1, 1, 1, 0, 8'h00, 8'h22, 1, 0, 1, "err_sticky");

        rst_pulse(1'b0, "async_reset_clears_err");

        // Priority among simultaneous controls.
        op(1, 1, 0, 0, 8'h32, 8'h32, 1, 0, 0, "jump_32");
        op(1, 0, 1, 0, 8'h99, 8'h99, 0, 0, 0, "call_99");
        op(0, 0, 0, 1, 8'h77, 8'h33, 1, 0, 0, "ret_wins");
        op(1, 0, 0, 1, 8'h44, 8'h44, 0, 0, 0, "call_over_jump");
        op(1, 1, 0, 1, 8'hFF, 8'hFF, 0, 0, 0, "jump_ff_co");
        op(1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0, "inc_wrap");

`ifdef PC_REL_BRANCH_EN
        op(1, 1, 0, 0, 8'h50, 8'h50, 0, 0, 0, "jump_50");
        rel(8'hF0, 8'h40, 0, "rel_back");
        op(1, 1, 0, 0, 8'hFE, 8'hFE, 0, 0, 0, "jump_fe");
        rel(8'h04, 8'h02, 0, "rel_wrap");
`endif

        // Reset mid-operation; first edge after release increments; stack empty.
        rst_pulse(1'b1, "async_reset_mid_op");
        op(0, 1, 1, 0, 8'h00, 8'h01, 1, 0, 1, "ret_after_reset");

        @(negedge clk);
        doRetBar = 1'b1; doCallBar = 1'b1; doJumpBar = 1'b1; incEn = 1'b0;
        for (int w = 0; w < 10 && q.size() > 0; w++)
            @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
